// File: rtl/mem_map_pkg.sv
// Shared address map, STATUS bit layout and FIFO sizing for the memory responder.
package mem_map_pkg;

  localparam logic [31:0] TXDATA_ADDR  = 32'h0000_1000;
  localparam logic [31:0] STATUS_ADDR  = 32'h0000_1004;
  localparam logic [31:0] TXCOUNT_ADDR = 32'h0000_1008;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BADADDR   = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_MSB = 8;

  localparam int FIFO_DEPTH_DEFAULT = 8;

  // Word-aligned compare: byte offset bits are ignored by the decoder.
  function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Show-ahead character FIFO with occupancy count; pop is ignored when empty,
// push is accepted when not full or when a pop frees a slot in the same cycle.
module tx_fifo
  import mem_map_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH_DEFAULT,
  parameter int DATA_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage array: written on accepted push, never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally (power-of-two depth); count keeps full/empty unambiguous.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_responder.sv
// CPU data-side responder: word RAM, TX character FIFO, STATUS and TXCOUNT
// registers, with sticky overflow and bad-address flags.
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int N          = 6,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic [7:0]  char_data,
  output logic        char_valid,
  input  logic        char_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  logic [31:0]      ram [1<<N];
  logic [N-1:0]     ram_idx;
  logic             ram_hit;
  logic             tx_hit;
  logic             st_hit;
  logic             cnt_hit;
  logic             unmapped;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             push;
  logic             pop;
  logic             ovf_set;

  logic [15:0]      txcount;
  logic             ovf;
  logic             badaddr;
  logic [31:0]      status_word;

  assign ram_idx  = Addr[N+1:2];
  assign ram_hit  = (Addr[31:N+2] == '0);
  assign tx_hit   = word_match(Addr, TXDATA_ADDR);
  assign st_hit   = word_match(Addr, STATUS_ADDR);
  assign cnt_hit  = word_match(Addr, TXCOUNT_ADDR);
  assign unmapped = ~(ram_hit | tx_hit | st_hit | cnt_hit);

  assign char_valid = ~fifo_empty;
  assign pop        = char_valid & char_ready;
  assign push       = MemWrite & tx_hit;
  assign ovf_set    = push & fifo_full & ~pop;

  tx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (WriteData[7:0]),
    .pop       (pop),
    .head      (char_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Assemble the STATUS word from live FIFO state and the sticky flags.
  always_comb begin
    status_word                            = '0;
    status_word[ST_FULL]                   = fifo_full;
    status_word[ST_EMPTY]                  = fifo_empty;
    status_word[ST_BADADDR]                = badaddr;
    status_word[ST_OVF]                    = ovf;
    status_word[ST_COUNT_MSB:ST_COUNT_LSB] = 5'(fifo_count);
  end

  // Zero-latency load mux; TXDATA and unmapped addresses read as zero.
  always_comb begin
    ReadData = '0;
    if (ram_hit)      ReadData = ram[ram_idx];
    else if (st_hit)  ReadData = status_word;
    else if (cnt_hit) ReadData = {16'h0000, txcount};
  end

  // RAM store port; old data is visible to a same-cycle load.
  always_ff @(posedge clk) begin
    if (!rst && MemWrite && ram_hit) ram[ram_idx] <= WriteData;
  end

  // Pop counter and sticky flags; a TXCOUNT store clears, a coincident pop counts as one.
  always_ff @(posedge clk) begin
    if (rst) begin
      txcount <= '0;
      ovf     <= 1'b0;
      badaddr <= 1'b0;
    end else begin
      if (unmapped) badaddr <= 1'b1;
      if (ovf_set)  ovf     <= 1'b1;
      if (MemWrite && cnt_hit) txcount <= {15'h0000, pop};
      else if (pop)            txcount <= txcount + 16'd1;
    end
  end

endmodule
